// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request/ack ports and main-memory bus shared by the arbiter and its environment
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;

    // master: the caches plus the memory block, i.e. everything around the arbiter
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_write_en, mem_read_en, busy
    );

    // slave: the arbiter itself
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_write_en, mem_read_en, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-ported main memory between icache (read-only) and dcache (read/write)
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t            state, state_n;
    logic              owner_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic              any_req;
    logic              grant_d;

    assign any_req = bus.i_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // on conflict the requester that did not win last time gets the grant
    assign grant_d = bus.d_req & (~bus.i_req | ~last_d);

    // remember who won each grant; dcache counts as last owner out of reset
    always_ff @(posedge clk)
        if (!reset)
            last_d <= 1'b1;
        else if (state == IDLE && any_req)
            last_d <= grant_d;
`else
    assign grant_d = bus.d_req;
`endif

    // state register
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_n;

    // next-state: one issue cycle, MEM_LATENCY wait cycles, one ack cycle
    always_comb
        state_n = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
                  (state == ISSUE) ? WAIT :
                  (state == WAIT)  ? ((cnt == '0) ? DONE : WAIT) : IDLE;

    // outputs decoded from state and the latched owner/direction
    always_comb begin
        bus.mem_read_en  = (state == ISSUE) & ~we_q;
        bus.mem_write_en = (state == ISSUE) & we_q;
        bus.d_ack        = (state == DONE) & owner_d;
        bus.i_ack        = (state == DONE) & ~owner_d;
        bus.busy         = state != IDLE;
    end

    assign bus.mem_addr  = addr_q & ~ADDR_W'('hF);
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = line_q;
    assign bus.d_rdata   = line_q;

    // latch the winning request at grant, count out latency, capture the returned line
    always_ff @(posedge clk)
        if (!reset) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            line_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner_d <= grant_d;
                we_q    <= grant_d & bus.d_we;
                addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                wdata_q <= grant_d ? bus.d_wdata : '0;
            end
            if (state == ISSUE)
                cnt <= CNT_W'(MEM_LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0)
                line_q <= bus.mem_rdata;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table and sequence checks for mem_arbiter, default and MEM_LATENCY=1 builds
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus0();
    mem_arbiter_if bus1();

    mem_arbiter u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    mem_arbiter #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    function automatic logic [127:0] init_line(input logic [3:0] k);
        return {4{28'hC0DE000, k}};
    endfunction

    logic [127:0] mem [16];
    logic [15:0]  wr_valid;
    logic [127:0] rdq;

    always @(posedge clk) begin
        if (!reset)
            wr_valid <= '0;
        else if (bus0.mem_write_en) begin
            mem[bus0.mem_addr[7:4]]      <= bus0.mem_wdata;
            wr_valid[bus0.mem_addr[7:4]] <= 1'b1;
        end
        if (bus0.mem_read_en)
            rdq <= wr_valid[bus0.mem_addr[7:4]] ? mem[bus0.mem_addr[7:4]] : init_line(bus0.mem_addr[7:4]);
    end
    assign bus0.mem_rdata = rdq;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         i_req;
        logic [31:0]  i_addr;
        logic         d_req;
        logic         d_we;
        logic [31:0]  d_addr;
        logic [127:0] d_wdata;
        logic         e_i_ack;
        logic         e_d_ack;
        logic         e_rd;
        logic         e_wr;
        logic         e_busy;
        logic [31:0]  e_addr;
        logic [127:0] e_rdata;
    } vec_t;

    function automatic vec_t mkv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [127:0] dd, input logic eia,
                                 input logic eda, input logic erd, input logic ewr, input logic eb,
                                 input logic [31:0] ea, input logic [127:0] erdata);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        v.e_i_ack = eia; v.e_d_ack = eda; v.e_rd = erd; v.e_wr = ewr; v.e_busy = eb;
        v.e_addr = ea; v.e_rdata = erdata;
        return v;
    endfunction

    // two simultaneous reads; returns after both acks (or the cycle budget)
    task automatic run_pair(input int pass);
        int ci = -1;
        int cd = -1;
        bus0.i_req = 1'b1; bus0.i_addr = 32'hC4;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h88;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (bus0.i_ack) begin
                if (ci < 0) ci = c;
                check($sformatf("pair%0d i_rdata", pass), bus0.i_rdata, init_line(4'hC));
                bus0.i_req = 1'b0;
            end
            if (bus0.d_ack) begin
                if (cd < 0) cd = c;
                check($sformatf("pair%0d d_rdata", pass), bus0.d_rdata, init_line(4'h8));
                bus0.d_req = 1'b0;
            end
        end
`ifdef MEM_ARB_RR_EN
        check($sformatf("pair%0d i_ack cycle", pass), 128'(ci), 128'(4));
        check($sformatf("pair%0d d_ack cycle", pass), 128'(cd), 128'(9));
`else
        check($sformatf("pair%0d d_ack cycle", pass), 128'(cd), 128'(4));
        check($sformatf("pair%0d i_ack cycle", pass), 128'(ci), 128'(9));
`endif
    endtask

    vec_t tbl [12];
    localparam logic [127:0] W = 128'h11111111_22222222_33333333_44444444;

    initial begin
        int n_ack, n_rd, ack0, ack1, ack_c;
        logic seen;
        tbl[0]  = mkv(0, 0,     1, 1, 32'h40, W, 0, 0, 0, 0, 0, 32'h00, 0);
        tbl[1]  = mkv(0, 0,     1, 1, 32'h40, W, 0, 0, 0, 1, 1, 32'h40, 0);
        tbl[2]  = mkv(0, 0,     1, 1, 32'h40, W, 0, 0, 0, 0, 1, 32'h40, 0);
        tbl[3]  = mkv(0, 0,     1, 1, 32'h40, W, 0, 0, 0, 0, 1, 32'h40, 0);
        tbl[4]  = mkv(0, 0,     1, 1, 32'h40, W, 0, 1, 0, 0, 1, 32'h40, 0);
        tbl[5]  = mkv(0, 0,     0, 0, 0,      0, 0, 0, 0, 0, 0, 32'h40, 0);
        tbl[6]  = mkv(1, 32'h48, 0, 0, 0,     0, 0, 0, 0, 0, 0, 32'h40, 0);
        tbl[7]  = mkv(1, 32'h48, 0, 0, 0,     0, 0, 0, 1, 0, 1, 32'h40, 0);
        tbl[8]  = mkv(1, 32'h48, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h40, 0);
        tbl[9]  = mkv(1, 32'h48, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h40, 0);
        tbl[10] = mkv(1, 32'h48, 0, 0, 0,     0, 1, 0, 0, 0, 1, 32'h40, W);
        tbl[11] = mkv(0, 0,     0, 0, 0,      0, 0, 0, 0, 0, 0, 32'h40, 0);

        bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = 0; bus0.d_wdata = 0;
        bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
        bus1.mem_rdata = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst i_ack", bus0.i_ack, 0);
        check("rst d_ack", bus0.d_ack, 0);
        check("rst read_en", bus0.mem_read_en, 0);
        check("rst write_en", bus0.mem_write_en, 0);
        check("rst mem_addr", bus0.mem_addr, 0);
        check("rst mem_wdata", bus0.mem_wdata, 0);
        check("rst i_rdata", bus0.i_rdata, 0);
        check("rst d_rdata", bus0.d_rdata, 0);
        check("rst busy", bus0.busy, 0);
        reset = 1'b1;

        // dcache line write then icache read of the same line
        for (int n = 0; n < 12; n++) begin
            check($sformatf("r%0d i_ack", n), bus0.i_ack, tbl[n].e_i_ack);
            check($sformatf("r%0d d_ack", n), bus0.d_ack, tbl[n].e_d_ack);
            check($sformatf("r%0d read_en", n), bus0.mem_read_en, tbl[n].e_rd);
            check($sformatf("r%0d write_en", n), bus0.mem_write_en, tbl[n].e_wr);
            check($sformatf("r%0d busy", n), bus0.busy, tbl[n].e_busy);
            check($sformatf("r%0d mem_addr", n), bus0.mem_addr, tbl[n].e_addr);
            if (tbl[n].e_wr)
                check($sformatf("r%0d mem_wdata", n), bus0.mem_wdata, W);
            if (tbl[n].e_i_ack)
                check($sformatf("r%0d i_rdata", n), bus0.i_rdata, tbl[n].e_rdata);
            bus0.i_req = tbl[n].i_req; bus0.i_addr = tbl[n].i_addr;
            bus0.d_req = tbl[n].d_req; bus0.d_we = tbl[n].d_we;
            bus0.d_addr = tbl[n].d_addr; bus0.d_wdata = tbl[n].d_wdata;
            @(negedge clk);
        end

        // reset during WAIT aborts the read with no ack
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h80;
        repeat (2) @(negedge clk);
        check("abort busy in wait", bus0.busy, 1);
        reset = 1'b0; bus0.d_req = 1'b0;
        @(negedge clk);
        check("abort busy", bus0.busy, 0);
        check("abort read_en", bus0.mem_read_en, 0);
        check("abort write_en", bus0.mem_write_en, 0);
        check("abort d_ack", bus0.d_ack, 0);
        check("abort mem_addr", bus0.mem_addr, 0);
        reset = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.d_ack) n_ack++;
        end
        check("abort no d_ack", 128'(n_ack), 0);

        // simultaneous requests, twice
        run_pair(0);
        run_pair(1);

        // dcache read held one cycle past ack becomes a second transaction
        n_ack = 0; n_rd = 0; ack0 = -1; ack1 = -1;
        bus0.d_we = 1'b0; bus0.d_addr = 32'h90;
        for (int c = 0; c < 16; c++) begin
            if (bus0.mem_read_en) n_rd++;
            if (bus0.d_ack) begin
                if (n_ack == 0) ack0 = c; else ack1 = c;
                n_ack++;
            end
            bus0.d_req = c < 9;
            @(negedge clk);
        end
        check("b2b read pulses", 128'(n_rd), 2);
        check("b2b ack pulses", 128'(n_ack), 2);
        check("b2b ack0 cycle", 128'(ack0), 4);
        check("b2b ack1 cycle", 128'(ack1), 9);

        // MEM_LATENCY=1 build: ack in cycle 3 with data present during cycle 2
        seen = 1'b0; ack_c = -1; n_rd = 0;
        bus1.i_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            if (bus1.mem_read_en) n_rd++;
            if (bus1.i_ack) begin
                if (!seen) begin
                    ack_c = c;
                    check("lat1 i_rdata", bus1.i_rdata, {4{32'h6000_0000 | 32'(2)}});
                end
                seen = 1'b1;
            end
            bus1.i_req = !seen;
            bus1.mem_rdata = {4{32'h6000_0000 | 32'(c)}};
            @(negedge clk);
        end
        check("lat1 ack cycle", 128'(ack_c), 3);
        check("lat1 read pulses", 128'(n_rd), 1);
        check("lat1 idle busy", bus1.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
